// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register map and bit positions for the buffered MMIO UART
package mmio_uart_pkg;

  // Register offsets within the block (addr[7:0])
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_CYCLES = 8'h10;
  localparam logic [7:0] OFF_INSTRS = 8'h14;

  // STATUS bit positions
  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NONEMPTY  = 1;
  localparam int ST_RX_OVF       = 2;
  localparam int ST_TX_DROP      = 3;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  // CTRL write bits
  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/mmio_uart_buffered_if.sv
// rtl/mmio_uart_buffered_if.sv - CPU memory-stage bus between datapath and MMIO slave
interface mmio_uart_buffered_if;
  logic        stall;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic        sel;
  logic [31:0] rdata;

  modport master (output stall, addr, re, we, wdata, input sel, rdata);
  modport slave  (input stall, addr, re, we, wdata, output sel, rdata);
endinterface

// File: rtl/mmio_uart_buffered_sync_fifo.sv
// rtl/mmio_uart_buffered_sync_fifo.sv - synchronous FIFO with flush and push-when-full-with-pop
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  pushOk
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  popEff;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full   = count[DEPTH_LOG2];
  assign empty  = (count == '0);
  assign popEff = pop & ~empty;
  assign pushOk = push & (~full | popEff);
  assign head   = mem[rdPtr];

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popEff) rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popEff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (pushOk && !flush && !rst) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/mmio_uart_buffered.sv
// rtl/mmio_uart_buffered.sv - buffered UART MMIO slave with counters and RX interrupt
module mmio_uart_buffered
  import mmio_uart_pkg::*;
#(
  parameter int         DEPTH_LOG2      = 3,
  parameter int         COUNTER_WIDTH   = 32,
  parameter bit         RX_BACKPRESSURE = 1'b1,
  parameter logic [3:0] BASE_NIBBLE     = 4'h8
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_uart_buffered_if.slave     bus,
  input  logic                    instr_retire,
  output logic                    irq,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_valid,
  input  logic                    uart_tx_ready,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_rx_valid,
  output logic                    uart_rx_ready
);
  logic                     access, rdAcc, wrAcc, ctrlWr, flush;
  logic [7:0]               offset;
  logic                     txPush, txPushOk, txFull, txEmpty;
  logic                     rxPush, rxPushOk, rxPop, rxFull, rxEmpty;
  logic [DEPTH_LOG2:0]      txCount, rxCount;
  logic [7:0]               rxHead;
  logic                     rxOvf, txDrop, irqEn;
  logic [COUNTER_WIDTH-1:0] cycles, instrs;
  logic [31:0]              readVal;
  logic                     unusedBits;

  assign unusedBits = ^{bus.addr[27:8], bus.wdata[31:8]};

  assign bus.sel = (bus.addr[31:28] == BASE_NIBBLE);
  assign access  = bus.sel & (bus.re | bus.we) & ~bus.stall;
  assign rdAcc   = access & bus.re;
  assign wrAcc   = access & bus.we;
  assign offset  = bus.addr[7:0];
  assign ctrlWr  = wrAcc & (offset == OFF_CTRL);
  assign flush   = ctrlWr & bus.wdata[CTRL_FLUSH];

  assign txPush        = wrAcc & (offset == OFF_TXDATA);
  assign uart_tx_valid = ~txEmpty;
  assign rxPop         = rdAcc & (offset == OFF_RXDATA);
  assign uart_rx_ready = RX_BACKPRESSURE ? ~rxFull : 1'b1;
  assign rxPush        = uart_rx_valid & uart_rx_ready;
  assign irq           = ~rxEmpty & irqEn;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) txFifo (
    .clk(clk), .rst(rst), .push(txPush), .pushData(bus.wdata[7:0]),
    .pop(uart_tx_ready), .flush(flush), .head(uart_tx_data),
    .full(txFull), .empty(txEmpty), .count(txCount), .pushOk(txPushOk)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) rxFifo (
    .clk(clk), .rst(rst), .push(rxPush), .pushData(uart_rx_data),
    .pop(rxPop), .flush(flush), .head(rxHead),
    .full(rxFull), .empty(rxEmpty), .count(rxCount), .pushOk(rxPushOk)
  );

  // Read mux; RXDATA returns 0 when empty because the head is masked
  always_comb begin
    readVal = '0;
    case (offset)
      OFF_STATUS: begin
        readVal[ST_TX_NOT_FULL] = ~txFull;
        readVal[ST_RX_NONEMPTY] = ~rxEmpty;
        readVal[ST_RX_OVF]      = rxOvf;
        readVal[ST_TX_DROP]     = txDrop;
        readVal[ST_TX_COUNT_LSB +: 8] = 8'(txCount);
        readVal[ST_RX_COUNT_LSB +: 8] = 8'(rxCount);
      end
      OFF_RXDATA: readVal = rxEmpty ? 32'd0 : 32'(rxHead);
      OFF_CTRL:   readVal = 32'(irqEn);
      OFF_CYCLES: readVal = 32'(cycles);
      OFF_INSTRS: readVal = 32'(instrs);
      default:    readVal = '0;
    endcase
  end

  // Load data register: captured on a read access, held otherwise (including stall)
  always_ff @(posedge clk) begin
    if (rst) bus.rdata <= '0;
    else if (rdAcc) bus.rdata <= readVal;
  end

  // Sticky flags and irq enable; a new overflow/drop event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rxOvf  <= 1'b0;
      txDrop <= 1'b0;
      irqEn  <= 1'b0;
    end else begin
      if (ctrlWr && bus.wdata[CTRL_CLEAR]) begin
        rxOvf  <= 1'b0;
        txDrop <= 1'b0;
      end
      if (ctrlWr) irqEn <= bus.wdata[CTRL_IRQ_EN];
      if (txPush && !txPushOk) txDrop <= 1'b1;
      if (rxPush && !rxPushOk && !flush) rxOvf <= 1'b1;
    end
  end

  // Free-running cycle counter and retired-instruction counter; a write clears
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
      instrs <= '0;
    end else begin
      if (wrAcc && offset == OFF_CYCLES) cycles <= '0;
      else cycles <= cycles + 1'b1;
      if (wrAcc && offset == OFF_INSTRS) instrs <= '0;
      else if (instr_retire) instrs <= instrs + 1'b1;
    end
  end
endmodule

// File: tb/tb_mmio_uart_buffered.sv
// tb/tb_mmio_uart_buffered.sv - directed self-checking bench for mmio_uart_buffered
module tb_mmio_uart_buffered;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_retire = 1'b0;
  logic       irq;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_valid = 1'b0;
  logic       uart_rx_ready;
  int         checks = 0;
  int         errors = 0;

  mmio_uart_buffered_if bus();

  mmio_uart_buffered dut (
    .clk(clk), .rst(rst), .bus(bus), .instr_retire(instr_retire), .irq(irq),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuRead(input logic [31:0] a);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
    step();
    bus.re = 1'b0;
  endtask

  task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
    step();
    bus.we = 1'b0;
  endtask

  task automatic rxByte(input logic [7:0] b);
    uart_rx_data = b; uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    bus.stall = 1'b0; bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_rx_ready", 32'(uart_rx_ready), 32'd1);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    bus.addr = 32'h0000_0000; #1;
    check("sel_other", 32'(bus.sel), 32'd0);
    cpuRead(32'h8000_0000);
    check("sel_base", 32'(bus.sel), 32'd1);
    check("rst_status", bus.rdata, 32'h0000_0001);

    // TX path: two bytes held, then released on consecutive cycles
    cpuWrite(32'h8000_0008, 32'h41);
    cpuWrite(32'h8000_0008, 32'h42);
    cpuRead(32'h8000_0000);
    check("tx2_status", bus.rdata, 32'h0000_0201);
    uart_tx_ready = 1'b1; #1;
    check("tx_first", {23'd0, uart_tx_valid, uart_tx_data}, 32'h141);
    step();
    check("tx_second", {23'd0, uart_tx_valid, uart_tx_data}, 32'h142);
    step();
    check("tx_drained", 32'(uart_tx_valid), 32'd0);
    uart_tx_ready = 1'b0;

    // RX fill to full with backpressure
    for (int i = 0; i < 8; i++) rxByte(8'(8'h10 + i));
    check("rx_full_ready", 32'(uart_rx_ready), 32'd0);
    check("irq_disabled", 32'(irq), 32'd0);
    cpuRead(32'h8000_0000);
    check("rx8_status", bus.rdata, 32'h0008_0003);
    cpuRead(32'h8000_0004);
    check("rx_pop_0x10", bus.rdata, 32'h0000_0010);
    cpuRead(32'h8000_0000);
    check("rx7_status", bus.rdata, 32'h0007_0003);
    rxByte(8'h18);

    // Stall holds a pending RXDATA read for three cycles
    bus.addr = 32'h8000_0004; bus.re = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rdata", bus.rdata, 32'h0007_0003);
      check("stall_no_pop", 32'(uart_rx_ready), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    bus.re = 1'b0;
    check("unstall_pop", bus.rdata, 32'h0000_0011);
    cpuRead(32'h8000_0000);
    check("one_pop_status", bus.rdata, 32'h0007_0003);

    // TX overflow drop, flag clear, flush
    for (int i = 0; i < 9; i++) cpuWrite(32'h8000_0008, 32'(8'h50 + i));
    cpuRead(32'h8000_0000);
    check("tx_drop_status", bus.rdata, 32'h0007_080A);
    cpuWrite(32'h8000_000C, 32'h1);
    cpuRead(32'h8000_0000);
    check("clear_status", bus.rdata, 32'h0007_0802);
    cpuWrite(32'h8000_000C, 32'h2);
    cpuRead(32'h8000_0000);
    check("flush_status", bus.rdata, 32'h0000_0001);
    check("flush_tx_valid", 32'(uart_tx_valid), 32'd0);

    // Push into a full TX FIFO while the UART pops in the same cycle
    for (int i = 0; i < 8; i++) cpuWrite(32'h8000_0008, 32'(8'h60 + i));
    uart_tx_ready = 1'b1;
    cpuWrite(32'h8000_0008, 32'h68);
    uart_tx_ready = 1'b0;
    cpuRead(32'h8000_0000);
    check("full_pushpop_status", bus.rdata, 32'h0000_0800);
    check("full_pushpop_head", 32'(uart_tx_data), 32'h61);
    cpuRead(32'h8000_0020);
    check("unmapped_read", bus.rdata, 32'd0);
    cpuRead(32'h8000_0000);
    cpuRead(32'h8000_0004);
    check("rx_empty_read", bus.rdata, 32'd0);
    cpuWrite(32'h8000_000C, 32'h2);

    // Cycle counter: cleared at t, read at t+100
    cpuWrite(32'h8000_0010, 32'h0);
    repeat (99) @(posedge clk);
    #1;
    cpuRead(32'h8000_0010);
    check("cycles_99", bus.rdata, 32'd99);

    // Instruction counter, then clear colliding with an increment
    cpuWrite(32'h8000_0014, 32'h0);
    for (int i = 0; i < 5; i++) begin
      instr_retire = 1'b1; step();
      instr_retire = 1'b0; step();
    end
    cpuRead(32'h8000_0014);
    check("instrs_5", bus.rdata, 32'd5);
    instr_retire = 1'b1;
    cpuWrite(32'h8000_0014, 32'h0);
    instr_retire = 1'b0;
    cpuRead(32'h8000_0014);
    check("instrs_clear_wins", bus.rdata, 32'd0);

    // RX interrupt
    cpuWrite(32'h8000_000C, 32'h4);
    check("irq_en_empty", 32'(irq), 32'd0);
    rxByte(8'h99);
    check("irq_set", 32'(irq), 32'd1);
    cpuRead(32'h8000_000C);
    check("ctrl_read", bus.rdata, 32'd1);
    cpuRead(32'h8000_0004);
    check("irq_byte", bus.rdata, 32'h99);
    check("irq_clear", 32'(irq), 32'd0);

    // Reset mid-transfer discards FIFO contents
    cpuWrite(32'h8000_0008, 32'h77);
    rxByte(8'h55);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_rdata", bus.rdata, 32'd0);
    cpuRead(32'h8000_0000);
    check("rst2_status", bus.rdata, 32'h0000_0001);
    check("rst2_irq", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart_buffered.md
Name: mmio_uart_buffered

Overview:
- Parametrised memory-mapped I/O slave for the MIPS150 datapath. Successor to the unbuffered UART interface.
- Adds configurable-depth RX/TX byte FIFOs, sticky overflow/drop flags, optional RX backpressure, FIFO flush, a free-running cycle counter, a retired-instruction counter and a level RX interrupt.
- Sits between the CPU memory stage (execute-stage address, write-stage read data) and the UART core's ready/valid byte ports.

Parameters:
- DEPTH_LOG2, 3, log2 of each FIFO depth (depth 8); legal range 1..7.
- COUNTER_WIDTH, 32, width of the cycle and instruction counters; legal range 1..32, zero-extended on read.
- RX_BACKPRESSURE, 1: 1 = uart_rx_ready deasserts when the RX FIFO is full; 0 = uart_rx_ready is tied high, and a byte arriving while full is dropped and sets rx_ovf.
- BASE_NIBBLE, 4'h8, value of addr[31:28] that selects this block.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; suppresses all CPU-side side effects
- addr  in  32  execute-stage byte address
- re  in  1  load access
- we  in  1  store access (word)
- wdata  in  32  store data
- sel  out  1  combinational: addr[31:28]==BASE_NIBBLE
- rdata  out  32  registered load data, valid the cycle after the access
- instr_retire  in  1  one pulse per retired instruction
- irq  out  1  rx_nonempty & irq_en
- uart_tx_data  out  8  byte to the UART transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts a byte
- uart_rx_data  in  8  byte from the UART receiver
- uart_rx_valid  in  1  received byte present
- uart_rx_ready  out  1  receiver byte accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Access definition: access = sel & (re|we) & ~stall. With stall high there is no push, no pop, no clear, no flush, and rdata holds its value.
- Register offsets (addr[7:0]; other bits ignored):
  - 0x00 STATUS (RO): bit0 tx_not_full, bit1 rx_nonempty, bit2 rx_ovf, bit3 tx_drop, [15:8] tx_count, [23:16] rx_count, others 0.
  - 0x04 RXDATA (RO): {24'b0, head byte}; the read pops the FIFO. Reading an empty FIFO returns 0 and does not pop.
  - 0x08 TXDATA (WO): wdata[7:0] is pushed.
  - 0x0C CTRL: write bit0 clears rx_ovf and tx_drop; bit1 flushes both FIFOs; bit2 sets irq_en (stored). Read returns {29'b0, 0, 0, irq_en}.
  - 0x10 CYCLES: read returns the counter value in the access cycle; any write clears it to 0 at the next edge.
  - 0x14 INSTRS: same as CYCLES, but increments on instr_retire.
  - Unmapped offsets: read 0, writes ignored.
- Load latency: rdata is registered from the access cycle; it is valid one edge later, matching the write stage.
- TX push rule: a push is accepted if not full, or if full and the UART pops in the same cycle. Otherwise the byte is dropped and tx_drop is set.
- TX pop: uart_tx_valid & uart_tx_ready pops. uart_tx_data is the head byte, driven combinationally from the FIFO.
- RX push: uart_rx_valid & uart_rx_ready pushes. With RX_BACKPRESSURE=0 and the FIFO full, the push succeeds only if the CPU pops in the same cycle; otherwise the byte is dropped and rx_ovf is set.
- Simultaneous push and pop on an empty FIFO: the push proceeds and the pop is suppressed, since valid is low.
- Counts: counts are DEPTH_LOG2+1 bits wide, zero-extended into the 8-bit fields. Pointers wrap modulo depth.
- Flush vs. UART push: a flush in the same cycle as a UART push leaves the FIFO empty; the incoming byte is discarded without setting rx_ovf.
- Counters: counters wrap at 2^COUNTER_WIDTH. A clear in the same cycle as an increment yields 0.
- Reset values:
  - FIFOs empty; flags 0; irq_en 0; counters 0; rdata 0.
  - uart_tx_valid 0; uart_rx_ready 1; irq 0.
  - Reset mid-transfer discards all FIFO contents.

Decomposition:
- Shared package mmio_uart_pkg holds:
  - register offset localparams (OFF_STATUS..OFF_INSTRS);
  - STATUS bit-position constants;
  - CTRL bit constants.
- One natural sub-module, sync_fifo (params WIDTH, DEPTH_LOG2), instantiated twice. It provides push/pop/flush, full/empty/count, a combinational head output, and same-cycle push-when-full-with-pop.

Test Plan:
- Reset, then read 0x00 -> rdata=0x00000001; uart_rx_ready=1, uart_tx_valid=0, irq=0.
- Write 0x41 and 0x42 to 0x08 with uart_tx_ready=0 -> STATUS=0x00000201. Raise uart_tx_ready -> 0x41 then 0x42 on consecutive cycles, then uart_tx_valid=0.
- RX_BACKPRESSURE=1, push 8 bytes 0x10..0x17 -> uart_rx_ready=0 after the 8th and STATUS=0x00080003. Read 0x04 -> 0x10, and rx_count becomes 7.
- Hold stall=1 for 3 cycles during a 0x04 read with 8 bytes buffered -> rx_count stays 8 and rdata is unchanged. Deassert stall -> exactly one pop.
- With uart_tx_ready=0, write 9 bytes -> tx_count=8 and STATUS bit3=1. Write CTRL=0x1 -> bit3=0. Write CTRL=0x2 -> tx_count=0 and rx_count=0.
- Write 0x10 at cycle t, read 0x10 at cycle t+100 -> 99. Pulse instr_retire 5 times, read 0x14 -> 5. Set irq_en and push one RX byte -> irq=1.
